// File: rtl/instr_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// instr_sequencer_pkg
//   Shared definitions for the instruction sequencer:
//     seq_state_t  - sequencer FSM state encoding
//     HALT_INSTR   - the 9-bit opcode that stops the program
//     seq_is_busy  - true for the states that belong to a running instruction
// -----------------------------------------------------------------------------
package instr_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_FETCH = 3'd2,
        S_EXEC  = 3'd3,
        S_MEM   = 3'd4,
        S_WB    = 3'd5,
        S_HALT  = 3'd6,
        S_ERR   = 3'd7
    } seq_state_t;

    localparam logic [8:0] HALT_INSTR = 9'h1FF;

    // CLEAR through WB are the "program running" states; IDLE, HALT and ERR
    // are the resting states in which start is accepted.
    function automatic logic seq_is_busy(input seq_state_t s);
        return (s == S_CLEAR) || (s == S_FETCH) || (s == S_EXEC) ||
               (s == S_MEM)   || (s == S_WB);
    endfunction

endpackage

// File: rtl/instr_sequencer_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
//   Enable/clear counter that sticks at all-ones instead of wrapping.
//   Clear has priority over enable.
//
// Parameters
//   W       counter width
// Ports
//   clk_i   in   1   clock, rising edge
//   rst_ni  in   1   asynchronous active-low reset (count -> 0)
//   clr_i   in   1   synchronous clear
//   en_i    in   1   count enable
//   q_o     out  W   current count
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q_o = cnt_q;

endmodule

// File: rtl/instr_sequencer.sv
// -----------------------------------------------------------------------------
// instr_sequencer
//   Multi-cycle sequencer that walks one 9-bit instruction at a time through
//   FETCH, EXEC, optional MEM and WB.  It turns the combinational decoder
//   strobes into one-cycle-qualified strobes for the PC, instruction
//   register, data memory and register file, and owns start/halt.
//
// Optional feature (macro SEQ_MEM_TIMEOUT_EN):
//   When defined, a MEM phase that waits MEM_TIMEOUT consecutive cycles
//   without mem_ack moves the sequencer to ERR (mem_err=1, halt=1).  ERR is
//   left only through start or reset.  MEM_TIMEOUT exists only in this build.
//   When undefined, MEM waits forever and mem_err is tied to 0.
//
// Parameters
//   CNT_W           width of cycle_count / retire_count
//   MEM_TIMEOUT     MEM cycles without ack before ERR (macro build only)
// Ports
//   CLK             in   1      clock, rising edge
//   RESET_N         in   1      asynchronous active-low reset
//   start           in   1      begin program at PC 0 (IDLE/HALT/ERR only)
//   instruction     in   9      current IR contents
//   dec_mem_read    in   1      decoder: load
//   dec_mem_write   in   1      decoder: store
//   dec_branch_en   in   1      decoder: branch taken
//   dec_reg_wr_en   in   1      decoder: regfile write
//   dec_flag_write  in   1      decoder: compare-flag write
//   dec_ovf_write   in   1      decoder: overflow write
//   mem_ack         in   1      data memory done (MEM only)
//   pc_clr          out  1      clear PC
//   ir_load         out  1      latch ROM word into IR
//   pc_en           out  1      advance PC
//   pc_branch       out  1      take branch target when pc_en
//   mem_req         out  1      data memory request, held until ack
//   mem_we          out  1      request is a store
//   reg_wr_strobe   out  1      regfile write
//   flag_wr_strobe  out  1      flag register write
//   ovf_wr_strobe   out  1      overflow register write
//   busy            out  1      running (CLEAR..WB)
//   halt            out  1      program finished (HALT or ERR)
//   mem_err         out  1      memory timeout, sticky until start/reset
//   cycle_count     out  CNT_W  busy cycles since last start, saturating
//   retire_count    out  CNT_W  retired instructions, saturating
//   dbg_state_o     out  3      current FSM state (seq_state_t encoding)
// -----------------------------------------------------------------------------
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int CNT_W = 16
`ifdef SEQ_MEM_TIMEOUT_EN
    ,
    parameter int MEM_TIMEOUT = 15
`endif
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             start,
    input  logic [8:0]       instruction,
    input  logic             dec_mem_read,
    input  logic             dec_mem_write,
    input  logic             dec_branch_en,
    input  logic             dec_reg_wr_en,
    input  logic             dec_flag_write,
    input  logic             dec_ovf_write,
    input  logic             mem_ack,
    output logic             pc_clr,
    output logic             ir_load,
    output logic             pc_en,
    output logic             pc_branch,
    output logic             mem_req,
    output logic             mem_we,
    output logic             reg_wr_strobe,
    output logic             flag_wr_strobe,
    output logic             ovf_wr_strobe,
    output logic             busy,
    output logic             halt,
    output logic             mem_err,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] retire_count,
    output logic [2:0]       dbg_state_o
);

    // Handshake with data memory: mem_req rises on entry to MEM and stays
    // high (with mem_we stable) every MEM cycle until the cycle in which
    // mem_ack is seen high; that cycle completes the access and the request
    // drops in the following WB cycle.  mem_ack in any other state is ignored.

    seq_state_t state_q;
    seq_state_t state_d;

    logic       timeout_hit;

`ifdef SEQ_MEM_TIMEOUT_EN
    localparam int TO_W = $clog2(MEM_TIMEOUT + 1);

    // Counts MEM cycles already spent without ack; restarts whenever the
    // sequencer is outside MEM.
    logic [TO_W-1:0] to_cnt_q;
    logic [TO_W-1:0] to_cnt_d;

    always_comb begin
        to_cnt_d    = '0;
        timeout_hit = 1'b0;
        if ((state_q == S_MEM) && !mem_ack) begin
            to_cnt_d    = to_cnt_q + TO_W'(1);
            timeout_hit = (to_cnt_q == TO_W'(MEM_TIMEOUT - 1));
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_HALT, S_ERR: begin
                if (start) begin
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: state_d = S_FETCH;
            S_FETCH: state_d = S_EXEC;
            S_EXEC: begin
                // HALT takes priority over any decoder strobes it may carry.
                if (instruction == HALT_INSTR) begin
                    state_d = S_HALT;
                end else if (dec_mem_read || dec_mem_write) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (mem_ack) begin
                    state_d = S_WB;
                end else if (timeout_hit) begin
                    state_d = S_ERR;
                end
            end
            S_WB:    state_d = S_FETCH;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // Moore output decode (dec_* only gate strobes within their own state)
    // ---------------------------------------------------------------------
    always_comb begin
        pc_clr         = 1'b0;
        ir_load        = 1'b0;
        pc_en          = 1'b0;
        pc_branch      = 1'b0;
        mem_req        = 1'b0;
        mem_we         = 1'b0;
        reg_wr_strobe  = 1'b0;
        flag_wr_strobe = 1'b0;
        ovf_wr_strobe  = 1'b0;
        unique case (state_q)
            S_CLEAR: pc_clr  = 1'b1;
            S_FETCH: ir_load = 1'b1;
            S_MEM: begin
                mem_req = 1'b1;
                // A store wins if the decoder flags both read and write.
                mem_we  = dec_mem_write;
            end
            S_WB: begin
                pc_en          = 1'b1;
                pc_branch      = dec_branch_en;
                reg_wr_strobe  = dec_reg_wr_en;
                flag_wr_strobe = dec_flag_write;
                ovf_wr_strobe  = dec_ovf_write;
            end
            default: ;
        endcase
    end

    assign busy = seq_is_busy(state_q);
    assign halt = (state_q == S_HALT) || (state_q == S_ERR);

`ifdef SEQ_MEM_TIMEOUT_EN
    assign mem_err = (state_q == S_ERR);
`else
    assign mem_err = 1'b0;
`endif

    assign dbg_state_o = state_q;

    // ---------------------------------------------------------------------
    // Statistics counters.  CLEAR zeroes both (clear beats enable), so the
    // cycle count starts from the first FETCH of a fresh run.
    // ---------------------------------------------------------------------
    logic cnt_clr;
    logic cyc_en;
    logic ret_en;

    assign cnt_clr = (state_q == S_CLEAR);
    assign cyc_en  = busy;
    assign ret_en  = (state_q == S_WB);

    sat_counter #(
        .W (CNT_W)
    ) u_cycle_cnt (
        .clk_i  (CLK),
        .rst_ni (RESET_N),
        .clr_i  (cnt_clr),
        .en_i   (cyc_en),
        .q_o    (cycle_count)
    );

    sat_counter #(
        .W (CNT_W)
    ) u_retire_cnt (
        .clk_i  (CLK),
        .rst_ni (RESET_N),
        .clr_i  (cnt_clr),
        .en_i   (ret_en),
        .q_o    (retire_count)
    );

endmodule

// File: tb/tb_instr_sequencer.sv
// -----------------------------------------------------------------------------
// tb_instr_sequencer
//   Directed bench for instr_sequencer.  Each scenario task drives its own
//   stimulus and compares outputs against hand-computed values.  Inputs are
//   driven and outputs sampled 1 time unit after the rising clock edge.
// -----------------------------------------------------------------------------
module tb_instr_sequencer;

    localparam int CNT_W = 16;

    logic             CLK = 1'b0;
    logic             RESET_N = 1'b0;
    logic             start = 1'b0;
    logic [8:0]       instruction = 9'h000;
    logic             dec_mem_read = 1'b0;
    logic             dec_mem_write = 1'b0;
    logic             dec_branch_en = 1'b0;
    logic             dec_reg_wr_en = 1'b0;
    logic             dec_flag_write = 1'b0;
    logic             dec_ovf_write = 1'b0;
    logic             mem_ack = 1'b0;
    logic             pc_clr;
    logic             ir_load;
    logic             pc_en;
    logic             pc_branch;
    logic             mem_req;
    logic             mem_we;
    logic             reg_wr_strobe;
    logic             flag_wr_strobe;
    logic             ovf_wr_strobe;
    logic             busy;
    logic             halt;
    logic             mem_err;
    logic [CNT_W-1:0] cycle_count;
    logic [CNT_W-1:0] retire_count;
    logic [2:0]       dbg_state_o;

    int errors = 0;
    int checks = 0;

    instr_sequencer #(
        .CNT_W (CNT_W)
    ) dut (
        .CLK            (CLK),
        .RESET_N        (RESET_N),
        .start          (start),
        .instruction    (instruction),
        .dec_mem_read   (dec_mem_read),
        .dec_mem_write  (dec_mem_write),
        .dec_branch_en  (dec_branch_en),
        .dec_reg_wr_en  (dec_reg_wr_en),
        .dec_flag_write (dec_flag_write),
        .dec_ovf_write  (dec_ovf_write),
        .mem_ack        (mem_ack),
        .pc_clr         (pc_clr),
        .ir_load        (ir_load),
        .pc_en          (pc_en),
        .pc_branch      (pc_branch),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .reg_wr_strobe  (reg_wr_strobe),
        .flag_wr_strobe (flag_wr_strobe),
        .ovf_wr_strobe  (ovf_wr_strobe),
        .busy           (busy),
        .halt           (halt),
        .mem_err        (mem_err),
        .cycle_count    (cycle_count),
        .retire_count   (retire_count),
        .dbg_state_o    (dbg_state_o)
    );

    // ---------------- clock / watchdog ----------------
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        start          = 1'b0;
        instruction    = 9'h000;
        dec_mem_read   = 1'b0;
        dec_mem_write  = 1'b0;
        dec_branch_en  = 1'b0;
        dec_reg_wr_en  = 1'b0;
        dec_flag_write = 1'b0;
        dec_ovf_write  = 1'b0;
        mem_ack        = 1'b0;
    endtask

    task automatic do_reset();
        RESET_N = 1'b0;
        idle_inputs();
        tick();
        tick();
        RESET_N = 1'b1;
        tick();
    endtask

    // Pulses start for one edge; returns while the DUT sits in CLEAR.
    task automatic launch(input logic [8:0] ins);
        instruction = ins;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [11:0] strobes;
        RESET_N = 1'b0;
        idle_inputs();
        tick();
        tick();
        strobes = {pc_clr, ir_load, pc_en, pc_branch, mem_req, mem_we,
                   reg_wr_strobe, flag_wr_strobe, ovf_wr_strobe, busy, halt, mem_err};
        checks++;
        if (strobes !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected %b", strobes, 12'h000);
        end
        checks++;
        if ({cycle_count, retire_count} !== 32'h0) begin
            errors++;
            $display("FAIL reset_counts: got %0d/%0d expected 0/0", cycle_count, retire_count);
        end
        RESET_N = 1'b1;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || pc_clr !== 1'b0) begin
            errors++;
            $display("FAIL idle_without_start: busy=%b pc_clr=%b expected 0/0", busy, pc_clr);
        end
    endtask

    task automatic test_add();
        do_reset();
        dec_reg_wr_en  = 1'b1;
        dec_flag_write = 1'b1;
        launch(9'h012);
        checks++;
        if (pc_clr !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL add_clear: pc_clr=%b busy=%b expected 1/1", pc_clr, busy);
        end
        tick();
        checks++;
        if (ir_load !== 1'b1 || pc_clr !== 1'b0) begin
            errors++;
            $display("FAIL add_fetch: ir_load=%b pc_clr=%b expected 1/0", ir_load, pc_clr);
        end
        tick();
        checks++;
        if (pc_en !== 1'b0 || ir_load !== 1'b0) begin
            errors++;
            $display("FAIL add_exec: pc_en=%b ir_load=%b expected 0/0", pc_en, ir_load);
        end
        tick();
        checks++;
        if ({pc_en, pc_branch, reg_wr_strobe, flag_wr_strobe, ovf_wr_strobe} !== 5'b10110) begin
            errors++;
            $display("FAIL add_wb_strobes: got %b expected %b",
                     {pc_en, pc_branch, reg_wr_strobe, flag_wr_strobe, ovf_wr_strobe}, 5'b10110);
        end
        tick();
        checks++;
        if (retire_count !== 16'd1 || cycle_count !== 16'd3 || ir_load !== 1'b1) begin
            errors++;
            $display("FAIL add_after_wb: retire=%0d cycles=%0d ir_load=%b expected 1/3/1",
                     retire_count, cycle_count, ir_load);
        end
    endtask

    task automatic test_load();
        int mem_cyc;
        int we_seen;
        do_reset();
        dec_mem_read  = 1'b1;
        dec_reg_wr_en = 1'b1;
        launch(9'h040);
        tick();
        tick();
        tick();
        mem_cyc = 0;
        we_seen = 0;
        for (int n = 0; n < 20 && mem_req === 1'b1; n++) begin
            mem_cyc++;
            if (mem_we !== 1'b0) we_seen++;
            if (mem_cyc == 3) mem_ack = 1'b1;
            tick();
            mem_ack = 1'b0;
        end
        checks++;
        if (mem_cyc !== 3 || we_seen !== 0) begin
            errors++;
            $display("FAIL load_mem_req_len: req_cycles=%0d we_cycles=%0d expected 3/0", mem_cyc, we_seen);
        end
        checks++;
        if (pc_en !== 1'b1 || reg_wr_strobe !== 1'b1 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL load_wb: pc_en=%b reg_wr=%b mem_req=%b expected 1/1/0",
                     pc_en, reg_wr_strobe, mem_req);
        end
        tick();
        checks++;
        if (cycle_count !== 16'd6 || retire_count !== 16'd1) begin
            errors++;
            $display("FAIL load_counts: cycles=%0d retire=%0d expected 6/1", cycle_count, retire_count);
        end
    endtask

    task automatic test_store_stray_ack();
        do_reset();
        dec_mem_read  = 1'b1;
        dec_mem_write = 1'b1;
        dec_ovf_write = 1'b1;
        launch(9'h080);
        tick();
        mem_ack = 1'b1;      // stray ack during FETCH
        tick();
        mem_ack = 1'b0;
        checks++;
        if (mem_req !== 1'b0 || pc_en !== 1'b0) begin
            errors++;
            $display("FAIL store_exec: mem_req=%b pc_en=%b expected 0/0", mem_req, pc_en);
        end
        tick();
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1) begin
            errors++;
            $display("FAIL store_mem: mem_req=%b mem_we=%b expected 1/1", mem_req, mem_we);
        end
        tick();
        checks++;
        if (mem_req !== 1'b1 || pc_en !== 1'b0) begin
            errors++;
            $display("FAIL store_wait: mem_req=%b pc_en=%b expected 1/0", mem_req, pc_en);
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        checks++;
        if ({mem_req, pc_en, reg_wr_strobe, ovf_wr_strobe} !== 4'b0101) begin
            errors++;
            $display("FAIL store_wb: got %b expected %b",
                     {mem_req, pc_en, reg_wr_strobe, ovf_wr_strobe}, 4'b0101);
        end
    endtask

    task automatic test_branch();
        int br_cnt;
        int pen_cnt;
        do_reset();
        dec_branch_en = 1'b1;
        launch(9'h1C3);
        br_cnt  = 0;
        pen_cnt = 0;
        for (int i = 0; i < 5; i++) begin   // CLEAR, FETCH, EXEC, WB, FETCH
            if (pc_branch === 1'b1) br_cnt++;
            if (pc_en === 1'b1) pen_cnt++;
            tick();
        end
        checks++;
        if (br_cnt !== 1 || pen_cnt !== 1) begin
            errors++;
            $display("FAIL branch_pulse: branch_cycles=%0d pc_en_cycles=%0d expected 1/1", br_cnt, pen_cnt);
        end
    endtask

    task automatic test_halt();
        do_reset();
        dec_reg_wr_en = 1'b1;
        launch(9'h012);
        tick();   // FETCH
        tick();   // EXEC
        tick();   // WB
        tick();   // FETCH
        instruction   = 9'h1FF;
        dec_reg_wr_en = 1'b0;
        tick();   // EXEC
        tick();   // HALT
        checks++;
        if ({halt, busy, pc_en, ir_load} !== 4'b1000) begin
            errors++;
            $display("FAIL halt_enter: halt/busy/pc_en/ir_load=%b expected %b",
                     {halt, busy, pc_en, ir_load}, 4'b1000);
        end
        checks++;
        if (cycle_count !== 16'd5 || retire_count !== 16'd1) begin
            errors++;
            $display("FAIL halt_counts: cycles=%0d retire=%0d expected 5/1", cycle_count, retire_count);
        end
        tick();
        tick();
        tick();
        checks++;
        if (cycle_count !== 16'd5 || retire_count !== 16'd1 || halt !== 1'b1) begin
            errors++;
            $display("FAIL halt_frozen: cycles=%0d retire=%0d halt=%b expected 5/1/1",
                     cycle_count, retire_count, halt);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (pc_clr !== 1'b1 || halt !== 1'b0) begin
            errors++;
            $display("FAIL halt_restart: pc_clr=%b halt=%b expected 1/0", pc_clr, halt);
        end
        tick();
        checks++;
        if (cycle_count !== 16'd0 || retire_count !== 16'd0) begin
            errors++;
            $display("FAIL restart_counts: cycles=%0d retire=%0d expected 0/0", cycle_count, retire_count);
        end
    endtask

    task automatic test_reset_mid_mem();
        do_reset();
        dec_mem_read = 1'b1;
        launch(9'h040);
        tick();
        tick();
        tick();
        checks++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("FAIL midrst_in_mem: mem_req=%b expected 1", mem_req);
        end
        #2;
        RESET_N = 1'b0;
        #1;
        checks++;
        if ({mem_req, busy, cycle_count} !== {2'b00, 16'd0}) begin
            errors++;
            $display("FAIL midrst_async: mem_req=%b busy=%b cycles=%0d expected 0/0/0",
                     mem_req, busy, cycle_count);
        end
        tick();
        RESET_N = 1'b1;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL midrst_stays_idle: busy=%b mem_req=%b expected 0/0", busy, mem_req);
        end
    endtask

    task automatic test_start_ignored();
        do_reset();
        dec_reg_wr_en = 1'b1;
        launch(9'h012);
        start = 1'b1;        // held high for the whole instruction
        tick();              // FETCH
        checks++;
        if (pc_clr !== 1'b0 || ir_load !== 1'b1) begin
            errors++;
            $display("FAIL busy_start_fetch: pc_clr=%b ir_load=%b expected 0/1", pc_clr, ir_load);
        end
        tick();              // EXEC
        tick();              // WB
        tick();              // FETCH again, not CLEAR
        checks++;
        if (pc_clr !== 1'b0 || ir_load !== 1'b1 || retire_count !== 16'd1) begin
            errors++;
            $display("FAIL busy_start_ignored: pc_clr=%b ir_load=%b retire=%0d expected 0/1/1",
                     pc_clr, ir_load, retire_count);
        end
        start = 1'b0;
    endtask

`ifdef SEQ_MEM_TIMEOUT_EN
    task automatic test_mem_timeout();
        int n;
        do_reset();
        dec_mem_read = 1'b1;
        launch(9'h040);
        tick();
        tick();
        tick();
        n = 0;
        while (mem_req === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        checks++;
        if (n !== 15) begin
            errors++;
            $display("FAIL timeout_len: mem cycles=%0d expected 15", n);
        end
        checks++;
        if ({mem_err, halt, mem_req, busy} !== 4'b1100) begin
            errors++;
            $display("FAIL timeout_err: err/halt/req/busy=%b expected %b",
                     {mem_err, halt, mem_req, busy}, 4'b1100);
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        checks++;
        if (mem_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky: mem_err=%b expected 1", mem_err);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (mem_err !== 1'b0 || pc_clr !== 1'b1) begin
            errors++;
            $display("FAIL timeout_restart: mem_err=%b pc_clr=%b expected 0/1", mem_err, pc_clr);
        end
    endtask
`else
    task automatic test_mem_wait();
        int req_cyc;
        do_reset();
        dec_mem_read = 1'b1;
        launch(9'h040);
        tick();
        tick();
        tick();
        req_cyc = 0;
        for (int i = 0; i < 30; i++) begin
            if (mem_req === 1'b1 && mem_err === 1'b0 && halt === 1'b0) req_cyc++;
            tick();
        end
        checks++;
        if (req_cyc !== 30) begin
            errors++;
            $display("FAIL mem_wait_forever: req cycles=%0d expected 30", req_cyc);
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        checks++;
        if (pc_en !== 1'b1 || mem_req !== 1'b0 || mem_err !== 1'b0) begin
            errors++;
            $display("FAIL mem_wait_wb: pc_en=%b mem_req=%b mem_err=%b expected 1/0/0",
                     pc_en, mem_req, mem_err);
        end
    endtask
`endif

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_add();
        test_load();
        test_store_stray_ack();
        test_branch();
        test_halt();
        test_reset_mid_mem();
        test_start_ignored();
`ifdef SEQ_MEM_TIMEOUT_EN
        test_mem_timeout();
`else
        test_mem_wait();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
